// File: rtl/tracking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tracking_pkg
// Brief    : Shared types and constants for the colour-blob tracking channel.
// Revision : 1.0 - initial release
// ============================================================================
package tracking_pkg;

    localparam int c_coord_w   = 12;
    localparam int c_box_lanes = 4;

    typedef enum logic [1:0] {
        TRK_SEARCH  = 2'd0,
        TRK_ACQUIRE = 2'd1,
        TRK_LOCKED  = 2'd2,
        TRK_COAST   = 2'd3
    } track_state_t;

    // Lane order matches the packed lane arrays used by the datapath: x is lane 0.
    typedef struct packed {
        logic [c_coord_w-1:0] h;
        logic [c_coord_w-1:0] w;
        logic [c_coord_w-1:0] y;
        logic [c_coord_w-1:0] x;
    } box_t;

endpackage
`default_nettype wire

// File: rtl/track_box_filter.sv
`default_nettype none
// ============================================================================
// Module   : track_box_filter
// Brief    : Combinational 4-lane box update, IIR (3*box+det)/4 or bypass.
//            Smoothing is built only when TRACK_SMOOTH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module track_box_filter
    import tracking_pkg::*;
#(
    parameter int COORD_W = c_coord_w
) (
    input  logic [c_box_lanes-1:0][COORD_W-1:0] i_cur_box,
    input  logic [c_box_lanes-1:0][COORD_W-1:0] i_det_box,
    input  logic                                i_load_direct,
    output logic [c_box_lanes-1:0][COORD_W-1:0] o_nxt_box
);

`ifdef TRACK_SMOOTH_EN
    for (genvar i = 0; i < c_box_lanes; i++) begin : g_lane
        logic [COORD_W+1:0] w_sum;

        // Two guard bits hold 3*box + det without overflow before the shift.
        assign w_sum = ({2'b00, i_cur_box[i]} << 1) + {2'b00, i_cur_box[i]}
                     + {2'b00, i_det_box[i]};
        assign o_nxt_box[i] = i_load_direct ? i_det_box[i] : w_sum[COORD_W+1:2];
    end
`else
    logic w_unused_bypass;

    assign o_nxt_box       = i_det_box;
    assign w_unused_bypass = ^{i_cur_box, i_load_direct};
`endif

endmodule
`default_nettype wire

// File: rtl/track_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : track_lock_ctrl
// Brief    : Frame-rate lock FSM (search/acquire/locked/coast) producing a
//            stabilised bounding box. Optional smoothing: TRACK_SMOOTH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module track_lock_ctrl
    import tracking_pkg::*;
#(
    parameter int COORD_W      = c_coord_w,
    parameter int ACQ_FRAMES   = 3,
    parameter int COAST_FRAMES = 8,
    parameter int MAX_JUMP     = 64
) (
    input  logic               clock_50,
    input  logic               reset,
    input  logic               frame_end,
    input  logic               det_valid,
    input  logic [COORD_W-1:0] det_x,
    input  logic [COORD_W-1:0] det_y,
    input  logic [COORD_W-1:0] det_w,
    input  logic [COORD_W-1:0] det_h,
    output logic               box_valid,
    output logic [COORD_W-1:0] box_x,
    output logic [COORD_W-1:0] box_y,
    output logic [COORD_W-1:0] box_w,
    output logic [COORD_W-1:0] box_h,
    output logic               locked,
    output logic [1:0]         trk_state
);

    localparam logic [3:0]       c_acq_frames   = 4'(ACQ_FRAMES);
    localparam logic [7:0]       c_coast_frames = 8'(COAST_FRAMES);
    localparam logic [COORD_W:0] c_max_jump     = (COORD_W+1)'(MAX_JUMP);

    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    track_state_t                         r_state, w_state_nxt;
    logic [3:0]                           r_acq_cnt, w_acq_nxt, w_acq_inc;
    logic [7:0]                           r_miss_cnt, w_miss_nxt, w_miss_inc;
    logic [COORD_W-1:0]                   r_ref_x, r_ref_y, w_ref_x_nxt, w_ref_y_nxt;
    logic                                 r_hit, w_hit, w_consistent;
    logic [c_box_lanes-1:0][COORD_W-1:0]  r_det, w_det_in, w_det;
    logic [c_box_lanes-1:0][COORD_W-1:0]  r_box, w_box_filt;
    logic                                 r_box_valid;
    logic                                 w_box_upd, w_box_direct;

    assign w_det_in = {det_h, det_w, det_y, det_x};

    // A detection arriving with frame_end belongs to the closing frame, so bypass the latch.
    assign w_hit = r_hit | det_valid;
    assign w_det = det_valid ? w_det_in : r_det;

    assign w_consistent = w_hit
                       && (abs_diff(w_det[0], r_ref_x) <= c_max_jump)
                       && (abs_diff(w_det[1], r_ref_y) <= c_max_jump);

    assign w_acq_inc  = (&r_acq_cnt)  ? r_acq_cnt  : r_acq_cnt  + 4'd1;
    assign w_miss_inc = (&r_miss_cnt) ? r_miss_cnt : r_miss_cnt + 8'd1;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_hit <= 1'b0;
            r_det <= '0;
        end else if (frame_end) begin
            r_hit <= 1'b0;
            r_det <= '0;
        end else if (det_valid) begin
            r_hit <= 1'b1;
            r_det <= w_det_in;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acq_nxt    = r_acq_cnt;
        w_miss_nxt   = r_miss_cnt;
        w_ref_x_nxt  = r_ref_x;
        w_ref_y_nxt  = r_ref_y;
        w_box_upd    = 1'b0;
        w_box_direct = 1'b0;
        if (frame_end) begin
            case (r_state)
                TRK_SEARCH: begin
                    if (w_hit) begin
                        w_ref_x_nxt = w_det[0];
                        w_ref_y_nxt = w_det[1];
                        if (c_acq_frames <= 4'd1) begin
                            w_state_nxt  = TRK_LOCKED;
                            w_box_upd    = 1'b1;
                            w_box_direct = 1'b1;
                            w_miss_nxt   = 8'd0;
                            w_acq_nxt    = 4'd0;
                        end else begin
                            w_state_nxt = TRK_ACQUIRE;
                            w_acq_nxt   = 4'd1;
                        end
                    end
                end
                TRK_ACQUIRE: begin
                    if (w_consistent) begin
                        w_ref_x_nxt = w_det[0];
                        w_ref_y_nxt = w_det[1];
                        if (w_acq_inc >= c_acq_frames) begin
                            w_state_nxt  = TRK_LOCKED;
                            w_box_upd    = 1'b1;
                            w_box_direct = 1'b1;
                            w_miss_nxt   = 8'd0;
                            w_acq_nxt    = 4'd0;
                        end else begin
                            w_acq_nxt = w_acq_inc;
                        end
                    end else if (w_hit) begin
                        w_acq_nxt   = 4'd1;
                        w_ref_x_nxt = w_det[0];
                        w_ref_y_nxt = w_det[1];
                    end else begin
                        w_state_nxt = TRK_SEARCH;
                        w_acq_nxt   = 4'd0;
                    end
                end
                TRK_LOCKED: begin
                    if (w_consistent) begin
                        w_box_upd   = 1'b1;
                        w_ref_x_nxt = w_det[0];
                        w_ref_y_nxt = w_det[1];
                        w_miss_nxt  = 8'd0;
                    end else begin
                        w_state_nxt = TRK_COAST;
                        w_miss_nxt  = 8'd1;
                    end
                end
                TRK_COAST: begin
                    if (w_consistent) begin
                        w_state_nxt = TRK_LOCKED;
                        w_box_upd   = 1'b1;
                        w_ref_x_nxt = w_det[0];
                        w_ref_y_nxt = w_det[1];
                        w_miss_nxt  = 8'd0;
                    end else if (w_miss_inc >= c_coast_frames) begin
                        w_state_nxt = TRK_SEARCH;
                        w_miss_nxt  = 8'd0;
                        w_acq_nxt   = 4'd0;
                    end else begin
                        w_miss_nxt = w_miss_inc;
                    end
                end
                default: w_state_nxt = TRK_SEARCH;
            endcase
        end
    end

    track_box_filter #(
        .COORD_W (COORD_W)
    ) u_box_filter (
        .i_cur_box     (r_box),
        .i_det_box     (w_det),
        .i_load_direct (w_box_direct),
        .o_nxt_box     (w_box_filt)
    );

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_state     <= TRK_SEARCH;
            r_acq_cnt   <= 4'd0;
            r_miss_cnt  <= 8'd0;
            r_ref_x     <= '0;
            r_ref_y     <= '0;
            r_box       <= '0;
            r_box_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acq_cnt   <= w_acq_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_ref_x     <= w_ref_x_nxt;
            r_ref_y     <= w_ref_y_nxt;
            r_box_valid <= frame_end;
            if (w_box_upd) begin
                r_box <= w_box_filt;
            end
        end
    end

    assign box_valid = r_box_valid;
    assign box_x     = r_box[0];
    assign box_y     = r_box[1];
    assign box_w     = r_box[2];
    assign box_h     = r_box[3];
    assign locked    = (r_state == TRK_LOCKED) || (r_state == TRK_COAST);
    assign trk_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_track_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_track_lock_ctrl
// Brief    : Directed plus randomized frame stimulus against a frame-level
//            reference model of the lock controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_track_lock_ctrl;

    localparam int COORD_W      = 12;
    localparam int ACQ_FRAMES   = 3;
    localparam int COAST_FRAMES = 8;
    localparam int MAX_JUMP     = 64;
`ifdef TRACK_SMOOTH_EN
    localparam bit c_smooth = 1'b1;
`else
    localparam bit c_smooth = 1'b0;
`endif

    logic               clock_50 = 1'b0;
    logic               reset = 1'b0;
    logic               frame_end = 1'b0;
    logic               det_valid = 1'b0;
    logic [COORD_W-1:0] det_x = '0, det_y = '0, det_w = '0, det_h = '0;
    logic               box_valid, locked;
    logic [COORD_W-1:0] box_x, box_y, box_w, box_h;
    logic [1:0]         trk_state;

    int total = 0;
    int bad   = 0;

    // Frame-level model: mode 0=search 1=acquire 2=locked 3=coast
    int m_mode, m_acq, m_miss, m_rx, m_ry, m_bx, m_by, m_bw, m_bh;

    track_lock_ctrl #(
        .COORD_W      (COORD_W),
        .ACQ_FRAMES   (ACQ_FRAMES),
        .COAST_FRAMES (COAST_FRAMES),
        .MAX_JUMP     (MAX_JUMP)
    ) dut (
        .clock_50  (clock_50),
        .reset     (reset),
        .frame_end (frame_end),
        .det_valid (det_valid),
        .det_x     (det_x),
        .det_y     (det_y),
        .det_w     (det_w),
        .det_h     (det_h),
        .box_valid (box_valid),
        .box_x     (box_x),
        .box_y     (box_y),
        .box_w     (box_w),
        .box_h     (box_h),
        .locked    (locked),
        .trk_state (trk_state)
    );

    always #5 clock_50 = ~clock_50;

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int blend(input int b, input int d);
        return c_smooth ? (((3 * b) + d) >> 2) & 12'hFFF : d;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_acq = 0; m_miss = 0; m_rx = 0; m_ry = 0;
        m_bx = 0; m_by = 0; m_bw = 0; m_bh = 0;
    endtask

    task automatic model_frame(input bit hit, input int x, input int y, input int w, input int h);
        bit cons;
        cons = hit && absd(x, m_rx) <= MAX_JUMP && absd(y, m_ry) <= MAX_JUMP;
        case (m_mode)
            0: if (hit) begin
                m_rx = x; m_ry = y;
                m_mode = 1; m_acq = 1;
            end
            1: if (cons) begin
                m_rx = x; m_ry = y; m_acq++;
                if (m_acq >= ACQ_FRAMES) begin
                    m_mode = 2; m_miss = 0;
                    m_bx = x; m_by = y; m_bw = w; m_bh = h;
                end
            end else if (hit) begin
                m_rx = x; m_ry = y; m_acq = 1;
            end else begin
                m_mode = 0; m_acq = 0;
            end
            2: if (cons) begin
                m_rx = x; m_ry = y; m_miss = 0;
                m_bx = blend(m_bx, x); m_by = blend(m_by, y);
                m_bw = blend(m_bw, w); m_bh = blend(m_bh, h);
            end else begin
                m_mode = 3; m_miss = 1;
            end
            default: if (cons) begin
                m_mode = 2; m_rx = x; m_ry = y; m_miss = 0;
                m_bx = blend(m_bx, x); m_by = blend(m_by, y);
                m_bw = blend(m_bw, w); m_bh = blend(m_bh, h);
            end else begin
                m_miss++;
                if (m_miss >= COAST_FRAMES) begin
                    m_mode = 0; m_miss = 0; m_acq = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string tag, input bit bv);
        check({tag, ".box_valid"}, box_valid, bv);
        check({tag, ".state"}, trk_state, m_mode);
        check({tag, ".locked"}, locked, (m_mode >= 2));
        check({tag, ".box_x"}, box_x, m_bx);
        check({tag, ".box_y"}, box_y, m_by);
        check({tag, ".box_w"}, box_w, m_bw);
        check({tag, ".box_h"}, box_h, m_bh);
    endtask

    // One frame: optional decoy detection (overwritten later), then the real
    // detection either mid-frame or coincident with frame_end.
    task automatic do_frame(input string tag, input bit has_det, input int x, input int y,
                            input int w, input int h, input bit coinc, input bit decoy);
        tick();
        if (has_det && decoy) begin
            det_valid = 1'b1;
            det_x = COORD_W'($urandom); det_y = COORD_W'($urandom);
            det_w = COORD_W'($urandom); det_h = COORD_W'($urandom);
            tick();
            det_valid = 1'b0;
        end
        repeat ($urandom_range(1, 3)) tick();
        if (has_det && !coinc) begin
            det_valid = 1'b1;
            det_x = COORD_W'(x); det_y = COORD_W'(y); det_w = COORD_W'(w); det_h = COORD_W'(h);
            tick();
            det_valid = 1'b0;
            tick();
        end
        check({tag, ".idle_bv"}, box_valid, 1'b0);
        frame_end = 1'b1;
        if (has_det && coinc) begin
            det_valid = 1'b1;
            det_x = COORD_W'(x); det_y = COORD_W'(y); det_w = COORD_W'(w); det_h = COORD_W'(h);
        end
        tick();
        frame_end = 1'b0;
        det_valid = 1'b0;
        model_frame(has_det, x, y, w, h);
        check_outputs(tag, 1'b1);
    endtask

    initial begin
        int cx, cy;
        bit has;
        model_reset();

        // Reset state
        repeat (3) tick();
        check_outputs("reset", 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) do_frame("empty", 0, 0, 0, 0, 0, 0, 0);
        check("empty.state_const", trk_state, 2'd0);

        do_frame("acq1", 1, 100, 100, 20, 20, 0, 0);
        do_frame("acq2", 1, 100, 100, 20, 20, 0, 1);
        do_frame("acq3", 1, 100, 100, 20, 20, 0, 0);
        check("lock.state_const", trk_state, 2'd2);
        check("lock.boxx_const", box_x, 12'd100);

        do_frame("move", 1, 110, 100, 20, 20, 0, 0);
        check("move.boxx_const", box_x, c_smooth ? 12'd102 : 12'd110);

        do_frame("jump", 1, 300, 100, 20, 20, 0, 0);
        check("jump.state_const", trk_state, 2'd3);
        check("jump.locked_const", locked, 1'b1);

        for (int i = 0; i < 3; i++) do_frame("coast", 0, 0, 0, 0, 0, 0, 0);
        do_frame("relock", 1, 105, 100, 22, 18, 0, 0);
        check("relock.state_const", trk_state, 2'd2);

        // Jump threshold: exactly MAX_JUMP is consistent, one more is not
        do_frame("edge64", 1, 105 + MAX_JUMP, 100, 22, 18, 0, 0);
        do_frame("edge65", 1, 105 + MAX_JUMP, 100 + MAX_JUMP + 1, 22, 18, 0, 0);
        do_frame("back", 1, 105 + MAX_JUMP, 100, 22, 18, 0, 0);

        for (int i = 0; i < COAST_FRAMES; i++) do_frame("drop", 0, 0, 0, 0, 0, 0, 0);
        check("drop.state_const", trk_state, 2'd0);

        do_frame("coinc", 1, 500, 600, 30, 40, 1, 1);
        check("coinc.state_const", trk_state, 2'd1);

        // Reset mid-ACQUIRE after a detection was latched
        tick();
        det_valid = 1'b1; det_x = 12'd505; det_y = 12'd600;
        tick();
        det_valid = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid", 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        do_frame("post_rst", 0, 0, 0, 0, 0, 0, 0);
        do_frame("restart", 1, 505, 600, 30, 40, 0, 0);

        // Randomized frames around a wandering centre
        cx = 2000; cy = 2000;
        for (int i = 0; i < 90; i++) begin
            int r;
            r = $urandom_range(0, 99);
            has = ((i / 15) % 2 == 1) ? (r >= 60) : (r >= 20);
            if (r < 30) begin
                cx = $urandom_range(0, 4095); cy = $urandom_range(0, 4095);
            end else begin
                cx = cx + $urandom_range(0, 100) - 50;
                cy = cy + $urandom_range(0, 100) - 50;
                if (cx < 0) cx = 0;
                if (cx > 4095) cx = 4095;
                if (cy < 0) cy = 0;
                if (cy > 4095) cy = 4095;
            end
            do_frame("rand", has, cx, cy, $urandom_range(0, 4095), $urandom_range(0, 4095),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
